// File: rtl/uart_frame_demux.sv
// ============================================================================
// uart_frame_demux : assembles tagged words from a UART byte stream, stages
//                    them per channel and publishes all channels on a commit.
// Revision 1.0
// ============================================================================
`default_nettype none

module uart_frame_demux #(
   parameter int BYTES       = 2,
   parameter int TAG_W       = 4,
   parameter int NUM_CH      = 7,
   parameter int COMMIT_TAG  = 15,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [7:0]                           rx_data,
   input  logic                                 rx_valid,
   output logic [NUM_CH*(8*BYTES-TAG_W)-1:0]    ch_data,
   output logic [NUM_CH-1:0]                    ch_upd,
   output logic                                 frame_valid,
   output logic                                 err_tag,
   output logic                                 err_timeout,
   output logic [7:0]                           err_cnt
);

   localparam int WORD_W = 8*BYTES;
   localparam int VAL_W  = WORD_W - TAG_W;
   localparam int DATA_W = NUM_CH*VAL_W;
   localparam int CNT_W  = (BYTES > 1) ? $clog2(BYTES+1) : 1;
   localparam int TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC+1) : 1;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_ACC  = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [TO_W-1:0]   to_q, to_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic              wvld_q, wvld_d;
   logic [DATA_W-1:0] stage_q, stage_d;
   logic [DATA_W-1:0] ch_data_q, ch_data_d;
   logic [NUM_CH-1:0] ch_upd_q, ch_upd_d;
   logic              frame_valid_q, frame_valid_d;
   logic              err_tag_q, err_tag_d;
   logic              err_timeout_q, err_timeout_d;
   logic [7:0]        err_cnt_q, err_cnt_d;

   logic [TAG_W-1:0]  w_tag;
   logic [VAL_W-1:0]  w_val;
   logic [1:0]        w_inc;
   logic [8:0]        w_sum;

   assign w_tag = word_q[WORD_W-1 -: TAG_W];
   assign w_val = word_q[VAL_W-1:0];

   // Byte assembly; cnt_q is the index of the next byte, counted from the MSB.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      to_d          = to_q;
      word_d        = word_q;
      wvld_d        = 1'b0;
      err_timeout_d = 1'b0;
      if (rx_valid) begin
         for (int b = 0; b < BYTES; b++) begin
            if (CNT_W'(b) == cnt_q)
               word_d[WORD_W-1-8*b -: 8] = rx_data;
         end
      end
      case (state_q)
         S_IDLE: begin
            to_d = '0;
            if (rx_valid) begin
               if (BYTES == 1) begin
                  wvld_d = 1'b1;
               end else begin
                  cnt_d   = CNT_W'(1);
                  state_d = S_ACC;
               end
            end
         end
         S_ACC: begin
            if (rx_valid) begin
               to_d = '0;
               if (cnt_q == CNT_W'(BYTES-1)) begin
                  wvld_d  = 1'b1;
                  cnt_d   = '0;
                  state_d = S_IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else if (to_q == TO_W'(TIMEOUT_CYC-1)) begin
               // This idle cycle is the TIMEOUT_CYC-th: drop the partial word.
               err_timeout_d = 1'b1;
               to_d          = '0;
               cnt_d         = '0;
               state_d       = S_IDLE;
            end else begin
               to_d = to_q + TO_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            to_d    = '0;
         end
      endcase
   end

   // Registered decode of the word completed on the previous edge.
   always_comb begin
      stage_d       = stage_q;
      ch_data_d     = ch_data_q;
      ch_upd_d      = '0;
      frame_valid_d = 1'b0;
      err_tag_d     = 1'b0;
      if (wvld_q) begin
         if (w_tag == '0) begin
            err_tag_d = 1'b0;
         end else if (int'(w_tag) <= NUM_CH) begin
            for (int k = 0; k < NUM_CH; k++) begin
               if (int'(w_tag) == k+1) begin
                  stage_d[k*VAL_W +: VAL_W] = w_val;
                  ch_upd_d[k]               = 1'b1;
               end
            end
         end else if (int'(w_tag) == COMMIT_TAG) begin
            ch_data_d     = stage_q;
            frame_valid_d = 1'b1;
         end else begin
            err_tag_d = 1'b1;
         end
      end
      w_inc     = {1'b0, err_tag_d} + {1'b0, err_timeout_d};
      w_sum     = {1'b0, err_cnt_q} + {7'b0, w_inc};
      err_cnt_d = w_sum[8] ? 8'hFF : w_sum[7:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         to_q          <= '0;
         word_q        <= '0;
         wvld_q        <= 1'b0;
         stage_q       <= '0;
         ch_data_q     <= '0;
         ch_upd_q      <= '0;
         frame_valid_q <= 1'b0;
         err_tag_q     <= 1'b0;
         err_timeout_q <= 1'b0;
         err_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         to_q          <= to_d;
         word_q        <= word_d;
         wvld_q        <= wvld_d;
         stage_q       <= stage_d;
         ch_data_q     <= ch_data_d;
         ch_upd_q      <= ch_upd_d;
         frame_valid_q <= frame_valid_d;
         err_tag_q     <= err_tag_d;
         err_timeout_q <= err_timeout_d;
         err_cnt_q     <= err_cnt_d;
      end
   end

   assign ch_data     = ch_data_q;
   assign ch_upd      = ch_upd_q;
   assign frame_valid = frame_valid_q;
   assign err_tag     = err_tag_q;
   assign err_timeout = err_timeout_q;
   assign err_cnt     = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_demux.sv
// ============================================================================
// tb_uart_frame_demux : table vectors, corner sequences and a randomized
//                       word-level reference comparison for uart_frame_demux.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_uart_frame_demux;

   localparam int T      = 1000;
   localparam int NCH    = 7;
   localparam int VW     = 12;

   logic                clk = 1'b0;
   logic                rst;
   logic [7:0]          rx_data;
   logic                rx_valid;
   logic [NCH*VW-1:0]   ch_data;
   logic [NCH-1:0]      ch_upd;
   logic                frame_valid;
   logic                err_tag;
   logic                err_timeout;
   logic [7:0]          err_cnt;

   int nchk = 0;
   int nerr = 0;

   uart_frame_demux #(
      .BYTES(2), .TAG_W(4), .NUM_CH(NCH), .COMMIT_TAG(15), .TIMEOUT_CYC(T)
   ) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .ch_data(ch_data), .ch_upd(ch_upd), .frame_valid(frame_valid),
      .err_tag(err_tag), .err_timeout(err_timeout), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [15:0] w);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
   endtask

   // Word-level reference model
   logic [11:0] m_stage [NCH];
   logic [11:0] m_commit[NCH];
   logic [NCH-1:0] m_upd;
   logic        m_fv, m_et;
   int          m_cnt;
   logic [15:0] wq[$];
   bit          mdl_en = 0;
   bit          chk_en = 0;

   function automatic logic [NCH*VW-1:0] pack(input logic [11:0] a[NCH]);
      logic [NCH*VW-1:0] r;
      for (int k = 0; k < NCH; k++) r[k*VW +: VW] = a[k];
      return r;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NCH; k++) begin
         m_stage[k]  = '0;
         m_commit[k] = '0;
      end
      m_upd = '0; m_fv = 0; m_et = 0; m_cnt = 0;
      wq.delete();
   endtask

   always @(posedge clk) begin
      if (mdl_en) begin
         logic [15:0] w;
         int tg;
         m_upd = '0; m_fv = 0; m_et = 0;
         if (wq.size() > 0) begin
            w  = wq.pop_front();
            tg = int'(w[15:12]);
            if (tg == 0) begin
            end else if (tg <= NCH) begin
               m_stage[tg-1] = w[11:0];
               m_upd[tg-1]   = 1'b1;
            end else if (tg == 15) begin
               for (int k = 0; k < NCH; k++) m_commit[k] = m_stage[k];
               m_fv = 1'b1;
            end else begin
               m_et  = 1'b1;
               m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("rnd_ch_data", 128'(ch_data), 128'(pack(m_commit)));
         chk("rnd_ch_upd", 128'(ch_upd), 128'(m_upd));
         chk("rnd_frame_valid", 128'(frame_valid), 128'(m_fv));
         chk("rnd_err_tag", 128'(err_tag), 128'(m_et));
         chk("rnd_err_timeout", 128'(err_timeout), 128'(0));
         chk("rnd_err_cnt", 128'(err_cnt), 128'(m_cnt));
      end
   end

   typedef struct {
      logic [15:0]    w;
      logic [NCH-1:0] upd;
      logic           fv;
      logic           et;
      logic [7:0]     cnt;
      logic [11:0]    c0;
      logic [11:0]    c1;
   } vec_t;

   vec_t        tbl[10];
   logic [11:0] ea[NCH];

   initial begin
      tbl[0] = '{16'h1ABC, 7'h01, 1'b0, 1'b0, 8'd0, 12'h000, 12'h000};
      tbl[1] = '{16'hF000, 7'h00, 1'b1, 1'b0, 8'd0, 12'hABC, 12'h000};
      tbl[2] = '{16'h2123, 7'h02, 1'b0, 1'b0, 8'd0, 12'hABC, 12'h000};
      tbl[3] = '{16'h9123, 7'h00, 1'b0, 1'b1, 8'd1, 12'hABC, 12'h000};
      tbl[4] = '{16'h0FFF, 7'h00, 1'b0, 1'b0, 8'd1, 12'hABC, 12'h000};
      tbl[5] = '{16'hF555, 7'h00, 1'b1, 1'b0, 8'd1, 12'hABC, 12'h123};
      tbl[6] = '{16'h8000, 7'h00, 1'b0, 1'b1, 8'd2, 12'hABC, 12'h123};
      tbl[7] = '{16'hE000, 7'h00, 1'b0, 1'b1, 8'd3, 12'hABC, 12'h123};
      tbl[8] = '{16'h7FFF, 7'h40, 1'b0, 1'b0, 8'd3, 12'hABC, 12'h123};
      tbl[9] = '{16'hFFFF, 7'h00, 1'b1, 1'b0, 8'd3, 12'hABC, 12'h123};

      rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_ch_data", 128'(ch_data), 128'(0));
      chk("reset_pulses", 128'({ch_upd, frame_valid, err_tag, err_timeout}), 128'(0));
      chk("reset_err_cnt", 128'(err_cnt), 128'(0));
      repeat (5) @(posedge clk);
      #1 chk("idle_outputs", 128'({ch_data, ch_upd, frame_valid, err_tag, err_timeout, err_cnt}), 128'(0));

      // Table vectors: each word then the decode cycle, then pulse release.
      for (int i = 0; i < 10; i++) begin
         send_word(tbl[i].w);
         chk($sformatf("v%0d_pre_upd", i), 128'(ch_upd), 128'(0));
         @(posedge clk); #1;
         chk($sformatf("v%0d_upd", i), 128'(ch_upd), 128'(tbl[i].upd));
         chk($sformatf("v%0d_fv", i), 128'(frame_valid), 128'(tbl[i].fv));
         chk($sformatf("v%0d_et", i), 128'(err_tag), 128'(tbl[i].et));
         chk($sformatf("v%0d_cnt", i), 128'(err_cnt), 128'(tbl[i].cnt));
         chk($sformatf("v%0d_ch0", i), 128'(ch_data[11:0]), 128'(tbl[i].c0));
         chk($sformatf("v%0d_ch1", i), 128'(ch_data[23:12]), 128'(tbl[i].c1));
         @(posedge clk); #1;
         chk($sformatf("v%0d_pulse_end", i), 128'({ch_upd, frame_valid, err_tag}), 128'(0));
      end

      // Asynchronous reset mid-cycle clears immediately.
      @(posedge clk); #3 rst = 1'b1;
      #1 chk("async_rst_ch_data", 128'(ch_data), 128'(0));
      chk("async_rst_err_cnt", 128'(err_cnt), 128'(0));
      @(posedge clk); #1 rst = 1'b0;

      // Reset mid-word drops the partial word silently.
      send_byte(8'h2A);
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      send_word(16'h3456);
      @(posedge clk); #1;
      chk("rst_midword_upd", 128'(ch_upd), 128'(7'h04));
      chk("rst_midword_err", 128'({err_tag, err_timeout, err_cnt}), 128'(0));

      // Atomic multi-channel update.
      for (int k = 0; k < NCH; k++) send_word(16'((k+1) << 12) | 16'(k+1));
      send_word(16'hF000);
      @(posedge clk); #1;
      for (int k = 0; k < NCH; k++) ea[k] = 12'(k+1);
      chk("atomic_base", 128'(ch_data), 128'(pack(ea)));
      for (int k = 1; k < NCH; k++) send_word(16'((k+1) << 12) | 16'(k * 12'h111));
      @(posedge clk); #1;
      chk("atomic_before_commit", 128'(ch_data), 128'(pack(ea)));
      send_word(16'hF123);
      chk("atomic_commit_latency", 128'(ch_data), 128'(pack(ea)));
      @(posedge clk); #1;
      for (int k = 1; k < NCH; k++) ea[k] = 12'(k * 12'h111);
      chk("atomic_after_commit", 128'(ch_data), 128'(pack(ea)));
      chk("atomic_fv", 128'(frame_valid), 128'(1));

      // Timeout resynchronisation.
      send_byte(8'h3F);
      repeat (T-1) @(posedge clk);
      #1 chk("timeout_early", 128'(err_timeout), 128'(0));
      @(posedge clk); #1;
      chk("timeout_pulse", 128'(err_timeout), 128'(1));
      chk("timeout_cnt", 128'(err_cnt), 128'(1));
      @(posedge clk); #1;
      chk("timeout_pulse_end", 128'(err_timeout), 128'(0));
      send_word(16'h3456);
      @(posedge clk); #1;
      chk("resync_upd", 128'(ch_upd), 128'(7'h04));
      send_word(16'hF000);
      @(posedge clk); #1;
      chk("resync_ch2", 128'(ch_data[35:24]), 128'(12'h456));

      // Byte on the exact expiry cycle is accepted.
      send_byte(8'h3A);
      repeat (T-1) @(posedge clk);
      #1 send_byte(8'hBC);
      chk("expiry_no_timeout", 128'(err_timeout), 128'(0));
      chk("expiry_cnt", 128'(err_cnt), 128'(1));
      @(posedge clk); #1;
      chk("expiry_upd", 128'(ch_upd), 128'(7'h04));
      send_word(16'hF000);
      @(posedge clk); #1;
      chk("expiry_ch2", 128'(ch_data[35:24]), 128'(12'hABC));

      // Saturation.
      for (int i = 0; i < 300; i++) send_word(16'h9123);
      @(posedge clk); #1;
      chk("sat_cnt", 128'(err_cnt), 128'(255));
      chk("sat_et", 128'(err_tag), 128'(1));
      @(posedge clk); #1;
      chk("sat_hold", 128'({err_tag, err_cnt}), 128'({1'b0, 8'd255}));

      // Randomized words against the reference model.
      rst = 1'b1;
      model_reset();
      #2 rst = 1'b0;
      @(posedge clk); #1;
      mdl_en = 1; chk_en = 1;
      for (int i = 0; i < 300; i++) begin
         logic [15:0] w;
         w = 16'($urandom);
         send_byte(w[15:8]);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #0 send_byte(w[7:0]);
         wq.push_back(w);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      repeat (3) @(posedge clk);
      #1 chk_en = 0; mdl_en = 0;

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

`default_nettype wire
